muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 170 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32IM multiply/divide unit: shift-add multiply, restoring divide, early-out specials.
// Optional MULDIV_FAST_MUL_EN: single-cycle multiply from the latched operands; divide stays iterative.
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic [2:0]      FUNC3,
    input  logic [XLEN-1:0] OPERAND_A,
    input  logic [XLEN-1:0] OPERAND_B,
    input  logic            FLUSH,
    output logic            BUSY,
    output logic            DONE,
    output logic [XLEN-1:0] RESULT
);

    localparam int unsigned CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [2:0]      func_q;
    logic [XLEN-1:0] opnd;
    logic [2*XLEN-1:0] acc;
    logic            neg_q;
    logic            neg_r;
    logic            special;

    logic            a_signed;
    logic            b_signed;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_abs;
    logic [XLEN-1:0] b_abs;
    logic            div_zero;
    logic            div_ovf;
    logic [XLEN-1:0] special_res;

    always_comb begin
        a_signed = (FUNC3 == 3'b001) || (FUNC3 == 3'b010) ||
                   (FUNC3 == 3'b100) || (FUNC3 == 3'b110);
        b_signed = (FUNC3 == 3'b001) || (FUNC3 == 3'b100) || (FUNC3 == 3'b110);
        a_neg    = a_signed && OPERAND_A[XLEN-1];
        b_neg    = b_signed && OPERAND_B[XLEN-1];
        a_abs    = a_neg ? -OPERAND_A : OPERAND_A;
        b_abs    = b_neg ? -OPERAND_B : OPERAND_B;
        div_zero = FUNC3[2] && (OPERAND_B == '0);
        div_ovf  = FUNC3[2] && !FUNC3[0] && (OPERAND_A == INT_MIN) && (OPERAND_B == '1);
        if (div_zero)
            special_res = FUNC3[1] ? OPERAND_A : '1;
        else
            special_res = FUNC3[1] ? '0 : OPERAND_A;
    end

    // acc holds {high product, multiplier} for multiply and {remainder, quotient} for divide.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     div_trial;
    logic [2*XLEN-1:0] div_next;

    always_comb begin
        mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opnd : '0)};
        mul_next  = {mul_sum, acc[XLEN-1:1]};
        div_trial = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
        if (div_trial[XLEN])
            div_next = {acc[2*XLEN-2:0], 1'b0};
        else
            div_next = {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end

    logic [2*XLEN-1:0] prod_raw;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   final_res;

    always_comb begin
        prod_raw = acc;
`ifdef MULDIV_FAST_MUL_EN
        if (!func_q[2])
            prod_raw = {{XLEN{1'b0}}, opnd} * {{XLEN{1'b0}}, acc[XLEN-1:0]};
`endif
        prod = neg_q ? -prod_raw : prod_raw;
        quot = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (func_q)
            3'b000:                 final_res = prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         final_res = quot;
            default:                final_res = rem;
        endcase
        if (special)
            final_res = acc[XLEN-1:0];
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= IDLE;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            RESULT  <= '0;
            count   <= '0;
            func_q  <= '0;
            opnd    <= '0;
            acc     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            special <= 1'b0;
        end else begin
            DONE <= 1'b0;
            if (FLUSH) begin
                state <= IDLE;
                BUSY  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (START) begin
                            func_q <= FUNC3;
                            neg_q  <= a_neg ^ b_neg;
                            neg_r  <= a_neg;
                            count  <= CW'(XLEN);
                            BUSY   <= 1'b1;
                            if (div_zero || div_ovf) begin
                                special <= 1'b1;
                                opnd    <= '0;
                                acc     <= {{XLEN{1'b0}}, special_res};
                                state   <= FINISH;
                            end else begin
                                special <= 1'b0;
                                if (FUNC3[2]) begin
                                    opnd  <= b_abs;
                                    acc   <= {{XLEN{1'b0}}, a_abs};
                                    state <= RUN;
                                end else begin
                                    opnd  <= a_abs;
                                    acc   <= {{XLEN{1'b0}}, b_abs};
`ifdef MULDIV_FAST_MUL_EN
                                    state <= FINISH;
`else
                                    state <= RUN;
`endif
                                end
                            end
                        end
                    end
                    RUN: begin
                        acc   <= func_q[2] ? div_next : mul_next;
                        count <= count - CW'(1);
                        if (count == CW'(1))
                            state <= FINISH;
                    end
                    FINISH: begin
                        RESULT <= final_res;
                        DONE   <= 1'b1;
                        BUSY   <= 1'b0;
                        state  <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                        BUSY  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: issued ops push expected result/latency, a DONE monitor checks them.
module tb_muldiv_unit;

    localparam int unsigned XLEN = 32;

    logic            CLK = 1'b0;
    logic            RESET;
    logic            START;
    logic [2:0]      FUNC3;
    logic [XLEN-1:0] OPERAND_A;
    logic [XLEN-1:0] OPERAND_B;
    logic            FLUSH;
    logic            BUSY;
    logic            DONE;
    logic [XLEN-1:0] RESULT;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .FUNC3(FUNC3),
        .OPERAND_A(OPERAND_A), .OPERAND_B(OPERAND_B), .FLUSH(FLUSH),
        .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  f;
        int          k;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] last_result = '0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      p;
        logic [63:0] up;
        logic [31:0] r;
        logic        ovf;
        sa  = longint'(signed'(a));
        sb  = longint'(signed'(b));
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        r   = '0;
        case (f)
            3'd0: begin p = sa * sb; r = p[31:0]; end
            3'd1: begin p = sa * sb; r = p[63:32]; end
            3'd2: begin p = sa * longint'({32'b0, b}); r = p[63:32]; end
            3'd3: begin up = {32'b0, a} * {32'b0, b}; r = up[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (ovf) r = a;
                else begin p = sa / sb; r = p[31:0]; end
            end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (ovf) r = '0;
                else begin p = sa % sb; r = p[31:0]; end
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && b == 0) return 1;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!f[2]) return 1;
`endif
        return XLEN + 1;
    endfunction

    always @(negedge CLK) begin
        if (DONE) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got DONE=1 RESULT=%h required no DONE", RESULT);
            end else begin
                mon_e = sb_q.pop_front();
                check32($sformatf("result_f%0d", mon_e.f), RESULT, mon_e.res);
                check_int($sformatf("latency_f%0d", mon_e.f), cyc - mon_e.k, mon_e.lat);
                check32("busy_in_done_cycle", {31'b0, BUSY}, 32'd0);
                last_result = mon_e.res;
            end
        end
    end

    // Called at posedge+1; waits for idle, presents the op, and records acceptance edge.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res);
        int   guard;
        exp_t e;
        guard = 0;
        while (BUSY && guard < 200) begin
            @(posedge CLK); #1;
            guard++;
        end
        if (BUSY) begin
            tests++;
            fails++;
            $display("FAIL busy_timeout: got BUSY=1 after %0d cycles required 0", guard);
        end
        FUNC3 = f; OPERAND_A = a; OPERAND_B = b; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        FUNC3 = 3'($urandom); OPERAND_A = $urandom; OPERAND_B = $urandom;
        e.res = res; e.f = f; e.k = cyc; e.lat = exp_lat(f, a, b);
        sb_q.push_back(e);
        check32("busy_after_start", {31'b0, BUSY}, 32'd1);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb_q.size() > 0 && guard < 200) begin
            @(posedge CLK); #1;
            guard++;
        end
        if (sb_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d pending ops required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        while (!DONE && guard < 200) begin
            @(posedge CLK); #1;
            guard++;
        end
        if (!DONE) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got DONE=0 required 1");
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    logic [2:0]  dir_f   [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                                  3'd5, 3'd6, 3'd4, 3'd6};
    logic [31:0] dir_a   [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                  -32'sd20, -32'sd20, 32'd20, 32'd20,
                                  32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] dir_b   [12] = '{-32'sd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2,
                                  32'd3, 32'd3, 32'd3, 32'd3,
                                  32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] dir_res [12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                                  32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'd6, 32'd2,
                                  32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};

    initial begin
        #3_000_000;
        fails++;
        $display("FAIL watchdog: got simulation still running required finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;

        RESET = 1'b1; START = 1'b0; FLUSH = 1'b0;
        FUNC3 = '0; OPERAND_A = '0; OPERAND_B = '0;
        repeat (3) @(posedge CLK);
        #1;
        check32("reset_busy", {31'b0, BUSY}, 32'd0);
        check32("reset_done", {31'b0, DONE}, 32'd0);
        check32("reset_result", RESULT, 32'd0);
        RESET = 1'b0;
        idle_cycles(2);

        for (int i = 0; i < 12; i++) begin
            issue(dir_f[i], dir_a[i], dir_b[i], dir_res[i]);
            drain();
        end

        // FLUSH ten cycles into a divide: no DONE, RESULT unchanged, next op normal.
        issue(3'd4, 32'd1000, 32'd7, 32'd142);
        idle_cycles(9);
        FLUSH = 1'b1;
        @(posedge CLK); #1;
        FLUSH = 1'b0;
        void'(sb_q.pop_back());
        check32("flush_busy", {31'b0, BUSY}, 32'd0);
        check32("flush_result_held", RESULT, last_result);
        idle_cycles(40);
        issue(3'd7, 32'd1000, 32'd7, 32'd6);
        drain();

        // FLUSH together with START in IDLE drops the request.
        FUNC3 = 3'd5; OPERAND_A = 32'd9; OPERAND_B = 32'd0; START = 1'b1; FLUSH = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0; FLUSH = 1'b0;
        check32("flush_start_dropped", {31'b0, BUSY}, 32'd0);
        idle_cycles(5);

        // Second START while busy is ignored.
        issue(3'd4, 32'd1000, 32'd7, 32'd142);
        idle_cycles(5);
        FUNC3 = 3'd0; OPERAND_A = 32'd3; OPERAND_B = 32'd5; START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
        drain();
        idle_cycles(40);

        // START in the DONE cycle, including back-to-back early-outs.
        issue(3'd0, 32'd7, 32'd3, 32'd21);
        wait_done();
        issue(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF);
        wait_done();
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        wait_done();
        issue(3'd7, 32'd20, 32'd3, 32'd2);
        drain();

        // RESET mid-run clears everything, including RESULT.
        check32("result_before_reset", RESULT, 32'd2);
        issue(3'd6, 32'd12345, 32'd77, 32'd25);
        idle_cycles(10);
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        sb_q.delete();
        last_result = '0;
        check32("midrun_reset_busy", {31'b0, BUSY}, 32'd0);
        check32("midrun_reset_done", {31'b0, DONE}, 32'd0);
        check32("midrun_reset_result", RESULT, 32'd0);
        idle_cycles(40);

        for (int i = 0; i < 150; i++) begin
            f = 3'($urandom_range(0, 7));
            a = pick_operand();
            b = pick_operand();
            issue(f, a, b, ref_model(f, a, b));
            if ($urandom_range(0, 3) == 0) begin
                drain();
                idle_cycles($urandom_range(0, 3));
            end
        end
        drain();
        idle_cycles(5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
